dct_transpose_buffer: RTL and testbench

//  Row-to-column transpose stage between the row-pass and column-pass integer DCTs of the 2D DCT.

---
 rtl/dct_transpose_buffer.sv | 108 ++++++++++
 tb/tb_dct_transpose_buffer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_transpose_buffer.sv
// Row-to-column transpose between 2D-DCT passes: round/shift/saturate rows into ping-pong banks, emit columns.
// First column valid one cycle after the last row of a block; in_ready drops only when both banks hold undrained blocks.
module dct_transpose_buffer #(
    parameter int DIM       = 8,
    parameter int IN_WIDTH  = 33,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 2
) (
    input  logic                                 HCLK,
    input  logic                                 HRESETn,
    input  logic                                 clr,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DIM-1:0][IN_WIDTH-1:0]         in_row,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DIM-1:0][OUT_WIDTH-1:0]        out_col,
    output logic [$clog2(DIM)-1:0]               out_idx,
    output logic                                 out_last
);
    localparam int AW = $clog2(DIM);
    localparam int XW = IN_WIDTH + 1;
    localparam logic [AW-1:0]        LAST    = AW'(DIM - 1);
    localparam logic signed [XW-1:0] RND     = XW'(1) << (SHIFT - 1);
    localparam logic signed [XW-1:0] SAT_MAX = XW'((longint'(1) << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] SAT_MIN = -SAT_MAX - XW'(1);

    // One extra bit of headroom so the rounding add never wraps before the shift.
    function automatic logic [OUT_WIDTH-1:0] rnd_sat(input logic [IN_WIDTH-1:0] x);
        logic signed [XW-1:0] ext;
        logic signed [XW-1:0] sum;
        logic signed [XW-1:0] sh;
        ext = $signed({x[IN_WIDTH-1], x});
        sum = ext + RND;
        sh  = sum >>> SHIFT;
        if (sh > SAT_MAX)
            sh = SAT_MAX;
        else if (sh < SAT_MIN)
            sh = SAT_MIN;
        return sh[OUT_WIDTH-1:0];
    endfunction

    logic [OUT_WIDTH-1:0] mem [2][DIM][DIM];
    logic                 wbank;
    logic                 rbank;
    logic [AW-1:0]        wrow;
    logic [AW-1:0]        rcol;
    logic [1:0]           full;
    logic                 wr_en;
    logic                 rd_en;

    assign in_ready  = !full[wbank];
    assign out_valid = full[rbank];
    assign wr_en     = in_valid && in_ready;
    assign rd_en     = out_valid && out_ready;

    // A completing write and a completing drain always target different banks,
    // so both updates to full[] can land in the same cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wbank <= 1'b0;
            rbank <= 1'b0;
            wrow  <= '0;
            rcol  <= '0;
            full  <= '0;
        end else if (clr) begin
            wbank <= 1'b0;
            rbank <= 1'b0;
            wrow  <= '0;
            rcol  <= '0;
            full  <= '0;
        end else begin
            if (wr_en) begin
                wrow <= wrow + 1'b1;
                if (wrow == LAST) begin
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                end
            end
            if (rd_en) begin
                rcol <= rcol + 1'b1;
                if (rcol == LAST) begin
                    full[rbank] <= 1'b0;
                    rbank       <= ~rbank;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int c = 0; c < DIM; c++)
                mem[wbank][wrow][c] <= rnd_sat(in_row[c]);
        end
    end

    always_comb begin
        out_col  = '0;
        out_idx  = '0;
        out_last = 1'b0;
        if (out_valid) begin
            for (int r = 0; r < DIM; r++)
                out_col[r] = mem[rbank][r][rcol];
            out_idx  = rcol;
            out_last = (rcol == LAST);
        end
    end
endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Scoreboard bench for dct_transpose_buffer at default parameters (DIM=8, 33->16 bits, SHIFT=2).
module tb_dct_transpose_buffer;
    typedef logic [7:0][32:0] row_t;
    typedef logic [7:0][15:0] col_t;
    typedef struct {
        col_t       col;
        logic [2:0] idx;
    } exp_t;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    row_t       in_row;
    logic       out_valid;
    logic       out_ready;
    col_t       out_col;
    logic [2:0] out_idx;
    logic       out_last;

    dct_transpose_buffer dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 HCLK = ~HCLK;

    int         checks = 0;
    int         errors = 0;
    int         stalls = 0;
    int         ncols  = 0;
    int         mrow   = 0;
    logic [15:0] rowbuf [8][8];
    exp_t       exp_q [$];

    task automatic chk(input string tag, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference rounding: floor((x + 2) / 4), clamped to 16-bit signed.
    function automatic logic [15:0] ref_sat(input logic [32:0] x);
        longint v;
        v = longint'($signed(x));
        v = (v + 2) >>> 2;
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    always @(negedge HCLK) begin
        exp_t e;
        if (!HRESETn || clr) begin
            mrow = 0;
            exp_q.delete();
        end else begin
            if (!out_valid)
                chk("idle_outputs", {out_col, out_idx, out_last}, '0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_col", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("col", out_col, e.col);
                    chk("idx", out_idx, e.idx);
                    chk("last", out_last, e.idx == 3'd7);
                end
                ncols++;
            end
            if (in_valid && in_ready) begin
                for (int c = 0; c < 8; c++)
                    rowbuf[mrow][c] = ref_sat(in_row[c]);
                if (mrow == 7) begin
                    for (int k = 0; k < 8; k++) begin
                        for (int r = 0; r < 8; r++)
                            e.col[r] = rowbuf[r][k];
                        e.idx = 3'(k);
                        exp_q.push_back(e);
                    end
                end
                mrow = (mrow + 1) % 8;
            end
        end
    end

    function automatic row_t rand_row();
        row_t   rr;
        longint v;
        for (int c = 0; c < 8; c++) begin
            v = longint'(int'($urandom_range(0, 2000000))) - 1000000;
            if ($urandom_range(0, 7) == 0)
                v = v * 4000;
            rr[c] = 33'(v);
        end
        return rr;
    endfunction

    task automatic send_row(input row_t r);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_row   = r;
        @(negedge HCLK);
        while (!in_ready && n < 200) begin
            @(negedge HCLK);
            n++;
        end
        if (!in_ready)
            chk("in_timeout", 0, 1);
        stalls += n;
        @(posedge HCLK);
        #1;
    endtask

    task automatic send_rand_block();
        for (int r = 0; r < 8; r++)
            send_row(rand_row());
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge HCLK);
            n++;
        end
        chk(tag, exp_q.size(), 0);
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk(tag, {in_ready, out_valid, out_col, out_idx, out_last}, {1'b1, 1'b0, 128'h0, 3'h0, 1'b0});
    endtask

    task automatic run_t1(input string tag);
        row_t r1;
        col_t c0;
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++)
                r1[c] = 33'((r * 8 + c) << 2);
            c0[r] = 16'(r * 8);
            if (r < 7) send_row(r1);
        end
        in_valid = 1'b1;
        in_row   = r1;
        @(negedge HCLK);
        chk({tag, "_rdy_row7"}, in_ready, 1'b1);
        chk({tag, "_vld_early"}, out_valid, 1'b0);
        @(posedge HCLK);
        #1;
        in_valid = 1'b0;
        @(negedge HCLK);
        chk({tag, "_vld_latency"}, out_valid, 1'b1);
        chk({tag, "_first_col"}, out_col, c0);
        drain({tag, "_drain"});
    endtask

    initial begin
        row_t tr;
        int   n;
        int   n0;
        HRESETn   = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_row    = '0;
        out_ready = 1'b0;
        #3;
        check_idle("reset_state");
        #20;
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        check_idle("post_reset");

        run_t1("t1");

        // T2: special values placed in column 0 of rows 0..4
        out_ready = 1'b0;
        for (int r = 0; r < 8; r++) begin
            tr = rand_row();
            case (r)
                0: tr[0] = 33'(6);
                1: tr[0] = 33'(-6);
                2: tr[0] = 33'(-5);
                3: tr[0] = 33'(longint'(1) << 20);
                4: tr[0] = 33'(-(longint'(1) << 20));
                default: ;
            endcase
            send_row(tr);
        end
        in_valid = 1'b0;
        @(negedge HCLK);
        chk("t2_vld", out_valid, 1'b1);
        chk("t2_round_pos", out_col[0], 16'd2);
        chk("t2_round_neg6", out_col[1], 16'hffff);
        chk("t2_round_neg5", out_col[2], 16'hffff);
        chk("t2_sat_max", out_col[3], 16'h7fff);
        chk("t2_sat_min", out_col[4], 16'h8000);
        @(posedge HCLK);
        #1;
        out_ready = 1'b1;
        drain("t2_drain");

        // T3: both banks fill under backpressure
        out_ready = 1'b0;
        send_rand_block();
        send_rand_block();
        in_valid = 1'b1;
        in_row   = rand_row();
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            chk("t3_full_rdy", in_ready, 1'b0);
        end
        @(posedge HCLK);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_idx == 3'd7) && n < 40) begin
            @(negedge HCLK);
            n++;
        end
        chk("t3_seen_col7", out_valid && out_idx == 3'd7, 1'b1);
        chk("t3_rdy_at_col7", in_ready, 1'b0);
        @(negedge HCLK);
        chk("t3_rdy_return", in_ready, 1'b1);
        drain("t3_drain");

        // T4: continuous streaming of 4 blocks
        n0 = ncols;
        out_ready = 1'b1;
        send_rand_block();
        stalls = 0;
        send_rand_block();
        send_rand_block();
        send_rand_block();
        in_valid = 1'b0;
        chk("t4_no_bubble", stalls, 0);
        drain("t4_drain");
        chk("t4_col_count", ncols - n0, 32);

        // T5: clear after row 3 of a block
        for (int r = 0; r < 4; r++)
            send_row(rand_row());
        in_valid = 1'b0;
        clr      = 1'b1;
        @(posedge HCLK);
        #1;
        clr = 1'b0;
        @(negedge HCLK);
        check_idle("t5_after_clr");
        @(posedge HCLK);
        #1;
        send_rand_block();
        in_valid = 1'b0;
        drain("t5_drain");

        // T6: async reset in the middle of a drain
        out_ready = 1'b1;
        send_rand_block();
        in_valid = 1'b0;
        n = 0;
        while (!(out_valid && out_idx == 3'd4) && n < 40) begin
            @(negedge HCLK);
            n++;
        end
        chk("t6_seen_col4", out_valid && out_idx == 3'd4, 1'b1);
        #2;
        HRESETn = 1'b0;
        #1;
        check_idle("t6_async_reset");
        repeat (2) @(negedge HCLK);
        #2;
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        check_idle("t6_post_release");
        run_t1("t6_t1");

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
